pipeline_hazard_ctrl: RTL

- Control and hazard end of the 5-stage MIPS datapath interface. Produces every control input the datapath consumes: decoded control, forwardA/forwardB, stall_needed, pcWrite, ifidWrite, ifidFlush, pcSrc.
- Decodes the IF/ID instruction.
- Keeps its own shadow pipeline of destination and control state for the ID/EX, EX/MEM and MEM/WB stages.
- Resolves load-use, branch-operand and taken-branch hazards, and keeps saturating stall and flush counters.

---
 rtl/pipeline_pkg.sv | 62 ++++++
 rtl/ctrl_decoder.sv | 53 +++++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS hazard/control block: opcodes, ALUop codes,
// forwarding select codes, decoded-control and shadow-stage structures, and
// the forwarding priority helper.
package pipeline_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } aluop_e;

   localparam logic [2:0] FWD_REG = 3'd0;
   localparam logic [2:0] FWD_WB  = 3'd1;
   localparam logic [2:0] FWD_MEM = 3'd2;

   // Destination/control state carried down the shadow pipeline.
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      logic       reg_write;
      logic       mem_read;
   } stage_t;

   // Decoder output; use_rs/use_rt/is_beq feed hazard detection only.
   typedef struct packed {
      logic   reg_dst;
      logic   alu_src;
      logic   mem_read;
      logic   mem_write;
      logic   reg_write;
      logic   mem_to_reg;
      aluop_e alu_op;
      logic   use_rs;
      logic   use_rt;
      logic   is_beq;
   } ctrl_t;

   // EX/MEM wins over MEM/WB because it holds the younger result.
   function automatic logic [2:0] fwd_sel(input logic [4:0] src,
                                          input logic       mem_wr,
                                          input logic [4:0] mem_dest,
                                          input logic       wb_wr,
                                          input logic [4:0] wb_dest);
      logic [2:0] sel;
      sel = FWD_REG;
      if (src != 5'd0) begin
         if (mem_wr && (mem_dest == src))
            sel = FWD_MEM;
         else if (wb_wr && (wb_dest == src))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode-to-control decoder.
// Ports:
//   opcode_i - ifid_ins[31:26]
//   ctrl_o   - decoded control plus source-usage/branch flags
module ctrl_decoder
   import pipeline_pkg::*;
(
   input  logic [5:0] opcode_i,
   output ctrl_t      ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_FUNCT;
            ctrl_o.use_rs    = 1'b1;
            ctrl_o.use_rt    = 1'b1;
         end
         OP_LW: begin
            ctrl_o.alu_src    = 1'b1;
            ctrl_o.mem_read   = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.alu_op     = ALU_ADD;
            ctrl_o.use_rs     = 1'b1;
         end
         OP_SW: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.use_rs    = 1'b1;
            ctrl_o.use_rt    = 1'b1;
         end
         OP_BEQ: begin
            ctrl_o.alu_op = ALU_SUB;
            ctrl_o.use_rs = 1'b1;
            ctrl_o.use_rt = 1'b1;
            ctrl_o.is_beq = 1'b1;
         end
         OP_ADDI: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.use_rs    = 1'b1;
         end
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Control and hazard unit for the 5-stage MIPS datapath. Decodes the IF/ID
// instruction, tracks ID/EX, EX/MEM and MEM/WB destinations in a shadow
// pipeline, and produces forwarding selects, load-use/branch stalls, branch
// redirect/flush and saturating stall/flush event counters.
// Ports:
//   clk, rst (async, active-low)
//   ifid_ins, regs_equal           - ID instruction and rs==rt comparator
//   regDst..memToReg, ALUop        - ID decoded control (zero on stall/reset)
//   pcSrc, pcWrite, ifidWrite, ifidFlush, stall_needed
//   forwardA, forwardB             - EX operand selects
//   stall_cnt, flush_cnt           - saturating event counters
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ifid_ins,
   input  logic             regs_equal,
   output logic             regDst,
   output logic             ALUsrc,
   output logic             memRead,
   output logic             memWrite,
   output logic             regWrite,
   output logic             memToReg,
   output logic [1:0]       ALUop,
   output logic             pcSrc,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             stall_needed,
   output logic [2:0]       forwardA,
   output logic [2:0]       forwardB,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ctrl_t            dec;
   stage_t           id_stage;
   stage_t           idex_q, idex_d;
   stage_t           exmem_q, memwb_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [4:0]       rs, rt, rd, dest;
   logic             load_use, br_stall, stall, taken, out_en;
   logic             unused_bits;

   ctrl_decoder u_dec (
      .opcode_i (ifid_ins[31:26]),
      .ctrl_o   (dec)
   );

   assign rs   = ifid_ins[25:21];
   assign rt   = ifid_ins[20:16];
   assign rd   = ifid_ins[15:11];
   assign dest = dec.reg_dst ? rd : rt;

   always_comb begin
      id_stage           = '0;
      id_stage.rs        = rs;
      id_stage.rt        = rt;
      id_stage.dest      = dest;
      id_stage.reg_write = dec.reg_write && (dest != 5'd0);
      id_stage.mem_read  = dec.mem_read;
   end

   assign load_use = idex_q.mem_read && (idex_q.dest != 5'd0) &&
                     ((dec.use_rs && (idex_q.dest == rs)) ||
                      (dec.use_rt && (idex_q.dest == rt)));

   // A load into $0 writes nothing, so it never holds a branch back.
   assign br_stall = dec.is_beq &&
                     ((idex_q.reg_write && ((idex_q.dest == rs) || (idex_q.dest == rt))) ||
                      (exmem_q.mem_read && (exmem_q.dest != 5'd0) &&
                       ((exmem_q.dest == rs) || (exmem_q.dest == rt))));

   assign stall  = rst && (load_use || br_stall);
   assign taken  = rst && dec.is_beq && !stall && regs_equal;
   assign out_en = rst && !stall;

   assign regDst       = out_en && dec.reg_dst;
   assign ALUsrc       = out_en && dec.alu_src;
   assign memRead      = out_en && dec.mem_read;
   assign memWrite     = out_en && dec.mem_write;
   assign regWrite     = out_en && dec.reg_write;
   assign memToReg     = out_en && dec.mem_to_reg;
   assign ALUop        = out_en ? dec.alu_op : 2'b00;
   assign pcSrc        = taken;
   assign pcWrite      = out_en;
   assign ifidWrite    = out_en;
   assign ifidFlush    = !rst || taken;
   assign stall_needed = stall;

   assign forwardA = rst ? fwd_sel(idex_q.rs, exmem_q.reg_write, exmem_q.dest,
                                   memwb_q.reg_write, memwb_q.dest) : FWD_REG;
   assign forwardB = rst ? fwd_sel(idex_q.rt, exmem_q.reg_write, exmem_q.dest,
                                   memwb_q.reg_write, memwb_q.dest) : FWD_REG;

   assign idex_d      = stall ? '0 : id_stage;
   assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   assign flush_cnt_d = (taken && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idex_q      <= '0;
         exmem_q     <= '0;
         memwb_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         idex_q      <= idex_d;
         exmem_q     <= idex_q;
         memwb_q     <= exmem_q;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

   assign unused_bits = ^{ifid_ins[10:0], memwb_q.rs, memwb_q.rt, memwb_q.mem_read};

endmodule
